// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, mux selects,
// opcode/funct constants, ALU operation codes and the one-hot instruction class.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [SEL_W-1:0] NPC_PC4    = 2'd0;
    localparam logic [SEL_W-1:0] NPC_BRANCH = 2'd1;
    localparam logic [SEL_W-1:0] NPC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] NPC_REG    = 2'd3;

    localparam logic [SEL_W-1:0] A3_RT = 2'd0;
    localparam logic [SEL_W-1:0] A3_RD = 2'd1;
    localparam logic [SEL_W-1:0] A3_RA = 2'd2;

    localparam logic [SEL_W-1:0] WD_ALUOUT = 2'd0;
    localparam logic [SEL_W-1:0] WD_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] WD_PC4    = 2'd2;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd2;
    localparam logic [ALU_W-1:0] ALU_LUI = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'd4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
    localparam logic [OP_W-1:0] FN_JR   = 6'b001000;

    // Exactly one bit is set for any instruction word.
    typedef struct packed {
        logic unk;
        logic jr;
        logic jal;
        logic beq;
        logic sw;
        logic lw;
        logic lui;
        logic ori;
        logic sll;
        logic subu;
        logic addu;
    } instr_cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output instr_cls_t  cls
);

    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_SLL:  cls.sll  = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: cls.unk  = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.unk = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: registered state, control decoded
// combinationally from state and the current IR contents.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               zero,
    output logic               pc_we,
    output logic [SEL_W-1:0]   npc_sel,
    output logic               ir_we,
    output logic               grf_we,
    output logic [SEL_W-1:0]   a3_sel,
    output logic [SEL_W-1:0]   wd_sel,
    output logic [ALU_W-1:0]   alu_op,
    output logic               alu_b_sel,
    output logic               ext_op,
    output logic               dm_we,
    output logic               retire,
    output logic [STATE_W-1:0] state
);

    state_e     state_q;
    state_e     state_n;
    instr_cls_t cls;
    logic       is_rtype;

    mc_decode u_decode (
        .instr (instr),
        .cls   (cls)
    );

    assign is_rtype = cls.addu | cls.subu | cls.sll;
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_n;
        end
    end

    // Path per class: jr/unknown end in ID, beq in EX, sw in MEM, rest in WB.
    always_comb begin
        state_n = S_IF;
        case (state_q)
            S_IF:  state_n = S_ID;
            S_ID:  begin
                if (cls.jr || cls.unk) begin
                    state_n = S_IF;
                end else if (cls.jal) begin
                    state_n = S_WB;
                end else begin
                    state_n = S_EX;
                end
            end
            S_EX:  begin
                if (cls.beq) begin
                    state_n = S_IF;
                end else if (cls.lw || cls.sw) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: state_n = cls.lw ? S_WB : S_IF;
            S_WB:  state_n = S_IF;
            default: state_n = S_IF;
        endcase
    end

    always_comb begin
        pc_we     = 1'b0;
        npc_sel   = NPC_PC4;
        ir_we     = 1'b0;
        grf_we    = 1'b0;
        a3_sel    = A3_RT;
        wd_sel    = WD_ALUOUT;
        alu_op    = ALU_ADD;
        alu_b_sel = cls.ori | cls.lui | cls.lw | cls.sw;
        ext_op    = cls.lw | cls.sw | cls.beq;
        dm_we     = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IF: begin
                pc_we = 1'b1;
                ir_we = 1'b1;
            end
            S_ID: begin
                if (cls.jr) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_REG;
                    retire  = 1'b1;
                end else if (cls.unk) begin
                    retire = 1'b1;
                end
            end
            S_EX: begin
                if (cls.subu || cls.beq) begin
                    alu_op = ALU_SUB;
                end else if (cls.ori) begin
                    alu_op = ALU_OR;
                end else if (cls.lui) begin
                    alu_op = ALU_LUI;
                end else if (cls.sll) begin
                    alu_op = ALU_SLL;
                end
                if (cls.beq) begin
                    pc_we   = zero;
                    npc_sel = NPC_BRANCH;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                if (cls.sw) begin
                    dm_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                grf_we = 1'b1;
                retire = 1'b1;
                if (cls.jal) begin
                    a3_sel  = A3_RA;
                    wd_sel  = WD_PC4;
                    pc_we   = 1'b1;
                    npc_sel = NPC_JUMP;
                end else if (cls.lw) begin
                    wd_sel = WD_MDR;
                end else if (is_rtype) begin
                    a3_sel = A3_RD;
                end
            end
            default: ;
        endcase
        // Reset overrides every write enable, even before the state register settles.
        if (reset) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            grf_we = 1'b0;
            dm_we  = 1'b0;
            retire = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, reset corner cases
// and randomized instructions against a step-indexed behavioural model.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        pc_we, ir_we, grf_we, alu_b_sel, ext_op, dm_we, retire;
    logic [1:0]  npc_sel, a3_sel, wd_sel;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .zero      (zero),
        .pc_we     (pc_we),
        .npc_sel   (npc_sel),
        .ir_we     (ir_we),
        .grf_we    (grf_we),
        .a3_sel    (a3_sel),
        .wd_sel    (wd_sel),
        .alu_op    (alu_op),
        .alu_b_sel (alu_b_sel),
        .ext_op    (ext_op),
        .dm_we     (dm_we),
        .retire    (retire),
        .state     (state)
    );

    always #5 clk = ~clk;

    logic [19:0] act;
    assign act = {state, pc_we, npc_sel, ir_we, grf_we, a3_sel, wd_sel,
                  alu_op, alu_b_sel, ext_op, dm_we, retire};

    typedef enum int {K_ADDU, K_SUBU, K_SLL, K_ORI, K_LUI, K_LW, K_SW,
                      K_BEQ, K_JAL, K_JR, K_UNK} kind_e;

    function automatic kind_e kind_of(logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h21) return K_ADDU;
            if (fn == 6'h23) return K_SUBU;
            if (fn == 6'h00) return K_SLL;
            if (fn == 6'h08) return K_JR;
            return K_UNK;
        end
        if (op == 6'h0D) return K_ORI;
        if (op == 6'h0F) return K_LUI;
        if (op == 6'h23) return K_LW;
        if (op == 6'h2B) return K_SW;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h03) return K_JAL;
        return K_UNK;
    endfunction

    function automatic int len_of(kind_e k);
        if (k == K_LW) return 5;
        if (k == K_BEQ || k == K_JAL) return 3;
        if (k == K_JR || k == K_UNK) return 2;
        return 4;
    endfunction

    // Expected output bundle on cycle s (0 = fetch) of executing ins.
    function automatic logic [19:0] model(logic [31:0] ins, logic z, int s);
        kind_e      k;
        logic       last, rty, pcw, grf, bsel, ext, dmw;
        logic [2:0] st;
        logic [1:0] npc, a3, wd;
        logic [3:0] alu;
        k    = kind_of(ins);
        last = (s == len_of(k) - 1);
        rty  = (k == K_ADDU || k == K_SUBU || k == K_SLL);
        if (s == 0)      st = S_IF;
        else if (s == 1) st = S_ID;
        else if (s == 2) st = (k == K_JAL) ? S_WB : S_EX;
        else if (s == 3) st = (k == K_LW || k == K_SW) ? S_MEM : S_WB;
        else             st = S_WB;
        pcw = (s == 0) || (k == K_JR && s == 1) || (k == K_BEQ && s == 2 && z)
              || (k == K_JAL && last);
        npc = NPC_PC4;
        if (k == K_JR && s == 1)       npc = NPC_REG;
        else if (k == K_BEQ && s == 2) npc = NPC_BRANCH;
        else if (k == K_JAL && last)   npc = NPC_JUMP;
        grf = (st == S_WB);
        a3  = A3_RT;
        wd  = WD_ALUOUT;
        if (st == S_WB) begin
            if (k == K_JAL) begin a3 = A3_RA; wd = WD_PC4; end
            else if (k == K_LW) wd = WD_MDR;
            else if (rty) a3 = A3_RD;
        end
        alu = ALU_ADD;
        if (st == S_EX) begin
            if (k == K_SUBU || k == K_BEQ) alu = ALU_SUB;
            else if (k == K_ORI) alu = ALU_OR;
            else if (k == K_LUI) alu = ALU_LUI;
            else if (k == K_SLL) alu = ALU_SLL;
        end
        bsel = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
        ext  = (k == K_LW || k == K_SW || k == K_BEQ);
        dmw  = (k == K_SW && st == S_MEM);
        return {st, pcw, npc, (s == 0), grf, a3, wd, alu, bsel, ext, dmw, last};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Runs one instruction from S_IF, checking every cycle; stops when back in S_IF.
    task automatic run_instr(input logic [31:0] ins, input logic z, output int cycles,
                             output logic grf_seen, output logic dm_seen);
        instr    = ins;
        zero     = z;
        cycles   = 0;
        grf_seen = 1'b0;
        dm_seen  = 1'b0;
        for (int guard = 0; guard < 8; guard++) begin
            #1;
            chk($sformatf("step%0d instr=%h", cycles, ins), 32'(act), 32'(model(ins, z, cycles)));
            if (cycles > 0) begin
                grf_seen |= grf_we;
                dm_seen  |= dm_we;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (state == S_IF) break;
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        z;
        int          len;
        logic        grf;
        logic        dm;
    } vec_t;

    vec_t        tbl[13];
    int          cyc;
    logic        g, d;
    logic [31:0] rnd, ins;
    logic        aborted_we;

    initial begin
        tbl[0]  = '{32'h00851021, 1'b0, 4, 1'b1, 1'b0};  // addu
        tbl[1]  = '{32'h00851023, 1'b1, 4, 1'b1, 1'b0};  // subu
        tbl[2]  = '{32'h00000000, 1'b0, 4, 1'b1, 1'b0};  // nop as sll $0
        tbl[3]  = '{32'h34880005, 1'b0, 4, 1'b1, 1'b0};  // ori
        tbl[4]  = '{32'h3C080012, 1'b0, 4, 1'b1, 1'b0};  // lui
        tbl[5]  = '{32'h8C880004, 1'b0, 5, 1'b1, 1'b0};  // lw
        tbl[6]  = '{32'hAC880004, 1'b0, 4, 1'b0, 1'b1};  // sw
        tbl[7]  = '{32'h1085FFFF, 1'b1, 3, 1'b0, 1'b0};  // beq taken
        tbl[8]  = '{32'h1085FFFF, 1'b0, 3, 1'b0, 1'b0};  // beq not taken
        tbl[9]  = '{32'h0C000C00, 1'b0, 3, 1'b1, 1'b0};  // jal
        tbl[10] = '{32'h03E00008, 1'b0, 2, 1'b0, 1'b0};  // jr $31
        tbl[11] = '{32'hFC000000, 1'b0, 2, 1'b0, 1'b0};  // unknown opcode
        tbl[12] = '{32'h0000003F, 1'b0, 2, 1'b0, 1'b0};  // unknown funct

        reset = 1'b1;
        instr = 32'h0C000C00;
        zero  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(state), 32'(S_IF));
        chk("reset enables", 32'({pc_we, ir_we, grf_we, dm_we, retire}), 32'(0));
        reset = 1'b0;
        #1;
        chk("first IF", 32'(act), 32'(model(instr, zero, 0)));

        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].ins, tbl[i].z, cyc, g, d);
            chk($sformatf("len vec%0d", i), 32'(cyc), 32'(tbl[i].len));
            chk($sformatf("grf vec%0d", i), 32'(g), 32'(tbl[i].grf));
            chk($sformatf("dm vec%0d", i), 32'(d), 32'(tbl[i].dm));
        end

        // Abort an lw in S_MEM: no register or memory write may leak out.
        instr      = 32'h8C880004;
        zero       = 1'b0;
        aborted_we = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            aborted_we |= grf_we | dm_we;
        end
        chk("lw in MEM", 32'(state), 32'(S_MEM));
        reset = 1'b1;
        #1;
        chk("reset in MEM enables", 32'({pc_we, ir_we, grf_we, dm_we, retire}), 32'(0));
        @(posedge clk);
        #1;
        chk("reset from MEM", 32'(state), 32'(S_IF));
        aborted_we |= grf_we | dm_we;
        chk("aborted lw writes", 32'(aborted_we), 32'(0));
        reset = 1'b0;
        run_instr(32'h8C880004, 1'b0, cyc, g, d);
        chk("lw after reset len", 32'(cyc), 32'(5));

        // Reset held across an instruction start keeps fetch quiet.
        instr = 32'h00851021;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("held reset state", 32'(state), 32'(S_IF));
        chk("held reset pc_we", 32'(pc_we), 32'(0));
        reset = 1'b0;

        for (int i = 0; i < 250; i++) begin
            rnd = $urandom;
            case ($urandom_range(0, 11))
                0:  ins = {6'h00, rnd[25:6], 6'h21};
                1:  ins = {6'h00, rnd[25:6], 6'h23};
                2:  ins = {6'h00, rnd[25:6], 6'h00};
                3:  ins = {6'h00, rnd[25:6], 6'h08};
                4:  ins = {6'h0D, rnd[25:0]};
                5:  ins = {6'h0F, rnd[25:0]};
                6:  ins = {6'h23, rnd[25:0]};
                7:  ins = {6'h2B, rnd[25:0]};
                8:  ins = {6'h04, rnd[25:0]};
                9:  ins = {6'h03, rnd[25:0]};
                default: ins = rnd;
            endcase
            run_instr(ins, 1'($urandom_range(0, 1)), cyc, g, d);
            chk($sformatf("rand len %h", ins), 32'(cyc), 32'(len_of(kind_of(ins))));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
